// File: rtl/lsu_ctrl_pkg.sv
// Shared types and constants for the load/store controller.
// Funct3 encodings, FSM states and the holding-register bundle.
package lsu_ctrl_pkg;

  localparam int LSU_TIMEOUT = 0;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP
  } lsu_state_e;

  typedef struct packed {
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } lsu_hold_t;

endpackage

// File: rtl/lsu_ctrl_if.sv
// Data bus between the LSU (master) and memory (slave).
// Request/ready address phase plus rvalid read-data phase.
interface lsu_ctrl_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/lsu_ctrl_align.sv
// Byte-lane steering for stores and lane extract/extend for loads.
// Also flags accesses that are not naturally aligned.
module lsu_ctrl_align
  import lsu_ctrl_pkg::*;
(
  input  logic [2:0]  st_op,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misaligned,
  input  logic [2:0]  ld_op,
  input  logic [1:0]  ld_lane,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [31:0] ld_sh;
  logic [15:0] ld_half;

  // Store side: enables, replicated data, alignment fault
  always_comb begin
    be         = 4'b1111;
    wdata      = st_data;
    misaligned = 1'b0;
    unique case (1'b1)
      st_op[1:0] == 2'b00: begin
        be    = 4'b0001 << st_addr[1:0];
        wdata = {4{st_data[7:0]}};
      end
      st_op[1:0] == 2'b01: begin
        be         = 4'b0011 << st_addr[1:0];
        wdata      = {2{st_data[15:0]}};
        misaligned = st_addr[0];
      end
      default: misaligned = |st_addr[1:0];
    endcase
  end

  assign ld_sh   = rdata >> {ld_lane, 3'b000};
  assign ld_half = ld_lane[1] ? rdata[31:16] : rdata[15:0];

  // Load side: pick lane, then sign or zero extend
  always_comb begin
    ld_data = rdata;
    unique case (1'b1)
      ld_op == F3_B:  ld_data = {{24{ld_sh[7]}}, ld_sh[7:0]};
      ld_op == F3_H:  ld_data = {{16{ld_half[15]}}, ld_half};
      ld_op == F3_BU: ld_data = {24'h0, ld_sh[7:0]};
      ld_op == F3_HU: ld_data = {16'h0, ld_half};
      default:        ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: sequences one bus access per MEM instruction,
// stalls the pipe while outstanding, reports misalign and timeout faults.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = LSU_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex2mem_mem_rd,
  input  logic            ex2mem_mem_wr,
  input  logic [2:0]      ex2mem_mem_op,
  input  logic [XLEN-1:0] ex2mem_alu_out,
  input  logic [XLEN-1:0] ex2mem_mem_wdata,
  input  logic            flush,
  lsu_ctrl_if.master      dbus,
  output logic [XLEN-1:0] lsu_rdata,
  output logic            lsu_stall,
  output logic            lsu_misaligned,
  output logic            lsu_bus_err,
  output logic [XLEN-1:0] lsu_exc_addr
);

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

  lsu_state_e  state, state_n;
  lsu_hold_t   hold;
  logic [31:0] cnt;
  logic        cnt_clr, cnt_inc, to_hit;
  logic        want, issue, mis_fault;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, ld_data;
  logic        al_mis;

  lsu_ctrl_align u_align (
    .st_op      (ex2mem_mem_op),
    .st_addr    (ex2mem_alu_out),
    .st_data    (ex2mem_mem_wdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .misaligned (al_mis),
    .ld_op      (hold.op),
    .ld_lane    (hold.addr[1:0]),
    .rdata      (dbus.rdata),
    .ld_data    (ld_data)
  );

  assign want      = ex2mem_mem_rd | ex2mem_mem_wr;
  assign issue     = (state == S_IDLE) & want & ~al_mis & ~flush;
  assign mis_fault = (state == S_IDLE) & want & al_mis & ~flush;
  assign to_hit    = (TIMEOUT > 0) && (cnt == TO_LAST);

  // Next state, bus drive and pipeline status
  always_comb begin
    state_n        = state;
    dbus.req       = 1'b0;
    dbus.we        = 1'b0;
    dbus.addr      = '0;
    dbus.be        = '0;
    dbus.wdata     = '0;
    lsu_rdata      = '0;
    lsu_stall      = 1'b0;
    lsu_misaligned = 1'b0;
    lsu_bus_err    = 1'b0;
    cnt_clr        = 1'b0;
    cnt_inc        = 1'b0;
    unique case (state)
      S_IDLE: begin
        lsu_misaligned = mis_fault;
        if (issue) begin
          dbus.req   = 1'b1;
          dbus.we    = ex2mem_mem_wr;
          dbus.addr  = {ex2mem_alu_out[31:2], 2'b00};
          dbus.be    = al_be;
          dbus.wdata = ex2mem_mem_wr ? al_wdata : '0;
          lsu_stall  = ~(dbus.ready & ex2mem_mem_wr);
          cnt_clr    = 1'b1;
          if (!dbus.ready) state_n = S_REQ;
          else if (!ex2mem_mem_wr) state_n = S_RESP;
        end
      end
      S_REQ: begin
        dbus.req   = 1'b1;
        dbus.we    = hold.we;
        dbus.addr  = {hold.addr[31:2], 2'b00};
        dbus.be    = hold.be;
        dbus.wdata = hold.wdata;
        if (dbus.ready) begin
          lsu_stall = ~hold.we;
          cnt_clr   = 1'b1;
          state_n   = hold.we ? S_IDLE : S_RESP;
        end else if (to_hit) begin
          lsu_bus_err = 1'b1;
          state_n     = S_IDLE;
        end else begin
          lsu_stall = 1'b1;
          cnt_inc   = 1'b1;
        end
      end
      S_RESP: begin
        if (dbus.rvalid) begin
          lsu_rdata = ld_data;
          state_n   = S_IDLE;
        end else if (to_hit) begin
          lsu_bus_err = 1'b1;
          state_n     = S_IDLE;
        end else begin
          lsu_stall = 1'b1;
          cnt_inc   = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Wait-cycle counter for the timeout check
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          cnt <= '0;
    else if (cnt_clr) cnt <= '0;
    else if (cnt_inc) cnt <= cnt + 32'd1;
  end

  // Capture the access so it survives EX/MEM changing under a stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold <= '0;
    end else if (issue) begin
      hold <= '{
        we:    ex2mem_mem_wr,
        op:    ex2mem_mem_op,
        addr:  ex2mem_alu_out,
        be:    al_be,
        wdata: ex2mem_mem_wr ? al_wdata : '0
      };
    end
  end

  // Faulting address, kept until the next fault
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 lsu_exc_addr <= '0;
    else if (lsu_misaligned) lsu_exc_addr <= ex2mem_alu_out;
    else if (lsu_bus_err)    lsu_exc_addr <= hold.addr;
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomised self-checking bench for lsu_ctrl against a
// transaction-level model of the access timing and lane rules.
module tb_lsu_ctrl;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd, wr, flush;
  logic [2:0]  op;
  logic [31:0] alu, wd;
  logic [31:0] lsu_rdata, lsu_exc_addr;
  logic        lsu_stall, lsu_misaligned, lsu_bus_err;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_exc;

  lsu_ctrl_if dbus();

  lsu_ctrl #(
    .XLEN    (32),
    .TIMEOUT (T)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .ex2mem_mem_rd    (rd),
    .ex2mem_mem_wr    (wr),
    .ex2mem_mem_op    (op),
    .ex2mem_alu_out   (alu),
    .ex2mem_mem_wdata (wd),
    .flush            (flush),
    .dbus             (dbus.master),
    .lsu_rdata        (lsu_rdata),
    .lsu_stall        (lsu_stall),
    .lsu_misaligned   (lsu_misaligned),
    .lsu_bus_err      (lsu_bus_err),
    .lsu_exc_addr     (lsu_exc_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ext(input logic [2:0] f,
                                      input logic [31:0] a,
                                      input logic [31:0] w);
    logic [31:0] s;
    s = w >> (8 * (a % 4));
    case (f)
      3'd0:    return int'($signed(s[7:0]));
      3'd1:    return int'($signed(s[15:0]));
      3'd4:    return s & 32'hFF;
      3'd5:    return s & 32'hFFFF;
      default: return w;
    endcase
  endfunction

  // One access from issue to completion, then `gap` idle cycles.
  // dly: cycles ready stays low from issue; rlat: RESP cycles before rvalid.
  task automatic run_access(input bit is_wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] din,
                            input logic [31:0] rw, input int dly,
                            input int rlat, input bit fl, input int gap);
    int          size, k, j;
    bit          mis, acc_done, timed;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_rd, e_addr;
    logic        e_st, e_err;
    size   = 1 << f3[1:0];
    mis    = (a % size) != 0;
    e_be   = 4'(((1 << size) - 1) << (a % 4));
    e_addr = a & ~32'd3;
    e_rd   = ext(f3, a, rw);
    case (f3[1:0])
      2'd0:    e_wd = din[7:0] * 32'h01010101;
      2'd1:    e_wd = din[15:0] * 32'h00010001;
      default: e_wd = din;
    endcase
    rd = !is_wr; wr = is_wr; op = f3; alu = a; wd = din;
    flush = fl; dbus.ready = (dly == 0); dbus.rvalid = 1'b0;
    dbus.rdata = $urandom;
    timed = 1'b0;
    if (fl || mis) begin
      @(negedge clk);
      checks++;
      if ({dbus.req, lsu_stall, lsu_misaligned, lsu_bus_err, lsu_rdata}
          !== {1'b0, 1'b0, 1'(mis && !fl), 1'b0, 32'd0}) begin
        errors++;
        $display("FAIL nobus a=%h fl=%0d: req/stall/mis/err/rdata=%b%b%b%b/%h exp mis=%0d",
                 a, fl, dbus.req, lsu_stall, lsu_misaligned, lsu_bus_err,
                 lsu_rdata, mis && !fl);
      end
      checks++;
      if (lsu_exc_addr !== exp_exc) begin
        errors++;
        $display("FAIL exc_addr got %h exp %h", lsu_exc_addr, exp_exc);
      end
      next_cycle();
      if (mis && !fl) exp_exc = a;
    end else begin
      k = 0; acc_done = 1'b0;
      while (!acc_done) begin
        if (k > 0) begin
          alu = $urandom; wd = $urandom; op = 3'($urandom);
          flush = 1'($urandom_range(0, 1));
          dbus.ready = (k >= dly); dbus.rdata = $urandom;
        end
        e_st = 1'b1; e_err = 1'b0;
        if (k == dly) begin
          if (is_wr) e_st = 1'b0;
          acc_done = 1'b1;
        end else if (k == T) begin
          e_st = 1'b0; e_err = 1'b1; acc_done = 1'b1; timed = 1'b1;
        end
        @(negedge clk);
        checks++;
        if ({dbus.req, dbus.we, dbus.addr, dbus.be}
            !== {1'b1, is_wr, e_addr, e_be}) begin
          errors++;
          $display("FAIL req cyc%0d: req/we/addr/be=%b/%b/%h/%b exp 1/%b/%h/%b",
                   k, dbus.req, dbus.we, dbus.addr, dbus.be, is_wr, e_addr, e_be);
        end
        if (is_wr) begin
          checks++;
          if (dbus.wdata !== e_wd) begin
            errors++;
            $display("FAIL wdata cyc%0d got %h exp %h", k, dbus.wdata, e_wd);
          end
        end
        checks++;
        if ({lsu_stall, lsu_misaligned, lsu_bus_err, lsu_rdata}
            !== {e_st, 1'b0, e_err, 32'd0}) begin
          errors++;
          $display("FAIL req status cyc%0d: stall/mis/err=%b%b%b rdata=%h exp %b0%b",
                   k, lsu_stall, lsu_misaligned, lsu_bus_err, lsu_rdata, e_st, e_err);
        end
        checks++;
        if (lsu_exc_addr !== exp_exc) begin
          errors++;
          $display("FAIL exc_addr got %h exp %h", lsu_exc_addr, exp_exc);
        end
        next_cycle();
        if (timed) exp_exc = a;
        k++;
      end
      if (!is_wr && !timed) begin
        j = 0; acc_done = 1'b0;
        while (!acc_done) begin
          alu = $urandom; wd = $urandom; op = 3'($urandom);
          flush = 1'($urandom_range(0, 1));
          dbus.ready = 1'b0; dbus.rvalid = (j == rlat);
          dbus.rdata = (j == rlat) ? rw : $urandom;
          e_st = 1'b1; e_err = 1'b0;
          if (j == rlat) begin
            e_st = 1'b0; acc_done = 1'b1;
          end else if (j == T - 1) begin
            e_st = 1'b0; e_err = 1'b1; acc_done = 1'b1; timed = 1'b1;
          end
          @(negedge clk);
          checks++;
          if ({dbus.req, lsu_stall, lsu_bus_err} !== {1'b0, e_st, e_err}) begin
            errors++;
            $display("FAIL resp cyc%0d: req/stall/err=%b%b%b exp 0%b%b",
                     j, dbus.req, lsu_stall, lsu_bus_err, e_st, e_err);
          end
          checks++;
          if (lsu_rdata !== ((j == rlat) ? e_rd : 32'd0)) begin
            errors++;
            $display("FAIL lsu_rdata op=%0d a=%h got %h exp %h", f3, a,
                     lsu_rdata, (j == rlat) ? e_rd : 32'd0);
          end
          checks++;
          if (lsu_exc_addr !== exp_exc) begin
            errors++;
            $display("FAIL exc_addr got %h exp %h", lsu_exc_addr, exp_exc);
          end
          next_cycle();
          if (timed) exp_exc = a;
          j++;
        end
      end
    end
    rd = 1'b0; wr = 1'b0; flush = 1'b0;
    dbus.ready = 1'b0; dbus.rvalid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      dbus.rvalid = 1'($urandom_range(0, 1));
      dbus.rdata  = $urandom;
      @(negedge clk);
      checks++;
      if ({dbus.req, lsu_stall, lsu_misaligned, lsu_bus_err, lsu_rdata}
          !== {4'b0000, 32'd0}) begin
        errors++;
        $display("FAIL idle: req/stall/mis/err=%b%b%b%b rdata=%h exp 0000/0",
                 dbus.req, lsu_stall, lsu_misaligned, lsu_bus_err, lsu_rdata);
      end
      next_cycle();
      dbus.rvalid = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({dbus.req, lsu_stall, lsu_misaligned, lsu_bus_err, lsu_rdata, lsu_exc_addr}
        !== {4'b0000, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL reset: req/stall/mis/err=%b%b%b%b rdata=%h exc=%h exp zeros",
               dbus.req, lsu_stall, lsu_misaligned, lsu_bus_err, lsu_rdata, lsu_exc_addr);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    exp_exc = 32'd0;
  endtask

  task automatic test_store_word;
    run_access(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'd0, 0, 0, 1'b0, 1);
  endtask

  task automatic test_store_byte;
    run_access(1'b1, 3'd0, 32'h103, 32'h000000A5, 32'd0, 3, 0, 1'b0, 1);
  endtask

  task automatic test_load_byte;
    run_access(1'b0, 3'd0, 32'h102, 32'd0, 32'h0080FF00, 0, 1, 1'b0, 1);
    run_access(1'b0, 3'd4, 32'h102, 32'd0, 32'h0080FF00, 2, 1, 1'b0, 1);
    run_access(1'b0, 3'd1, 32'h202, 32'd0, 32'h8001FF00, 1, 0, 1'b0, 1);
    run_access(1'b0, 3'd5, 32'h202, 32'd0, 32'h8001FF00, 0, 2, 1'b0, 1);
  endtask

  task automatic test_misaligned;
    run_access(1'b0, 3'd1, 32'h101, 32'd0, 32'd0, 0, 0, 1'b0, 1);
    run_access(1'b0, 3'd1, 32'h301, 32'd0, 32'd0, 0, 0, 1'b1, 1);
    run_access(1'b1, 3'd2, 32'h402, 32'h1234, 32'd0, 0, 0, 1'b0, 1);
    run_access(1'b1, 3'd2, 32'h500, 32'h1234, 32'd0, 0, 0, 1'b1, 1);
  endtask

  task automatic test_timeout;
    run_access(1'b0, 3'd2, 32'h600, 32'd0, 32'd0, 0, 99, 1'b0, 2);
    run_access(1'b1, 3'd1, 32'h702, 32'hBEEF, 32'd0, 99, 0, 1'b0, 2);
    run_access(1'b0, 3'd2, 32'h804, 32'd0, 32'hCAFEF00D, 4, 2, 1'b0, 1);
  endtask

  task automatic test_reset_mid;
    rd = 1'b1; wr = 1'b0; op = 3'd2; alu = 32'h200; wd = 32'd0;
    flush = 1'b0; dbus.ready = 1'b1; dbus.rvalid = 1'b0;
    next_cycle();
    rd = 1'b0; dbus.ready = 1'b0;
    #1;
    checks++;
    if (lsu_stall !== 1'b1) begin
      errors++;
      $display("FAIL resp stall before reset got %b exp 1", lsu_stall);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({dbus.req, lsu_stall} !== 2'b00) begin
      errors++;
      $display("FAIL reset mid-access req/stall=%b%b exp 00", dbus.req, lsu_stall);
    end
    next_cycle();
    rst = 1'b0;
    exp_exc = 32'd0;
    run_access(1'b0, 3'd2, 32'h204, 32'd0, 32'h13572468, 0, 1, 1'b0, 1);
  endtask

  task automatic test_back_to_back;
    run_access(1'b1, 3'd2, 32'h10, 32'h11223344, 32'd0, 0, 0, 1'b0, 0);
    run_access(1'b1, 3'd0, 32'h11, 32'h000000C3, 32'd0, 0, 0, 1'b0, 0);
    run_access(1'b0, 3'd2, 32'h14, 32'd0, 32'hA5A55A5A, 0, 0, 1'b0, 0);
    run_access(1'b1, 3'd1, 32'h16, 32'h0000F00F, 32'd0, 1, 0, 1'b0, 0);
    run_access(1'b0, 3'd5, 32'h1A, 32'd0, 32'h9ABC0000, 0, 2, 1'b0, 0);
    run_access(1'b0, 3'd0, 32'h1B, 32'd0, 32'h7F000000, 0, 0, 1'b0, 1);
  endtask

  task automatic test_random;
    bit          w;
    logic [2:0]  f;
    logic [31:0] a;
    int          sz;
    for (int n = 0; n < 150; n++) begin
      w = 1'($urandom_range(0, 1));
      if (w) f = 3'($urandom_range(0, 2));
      else   case ($urandom_range(0, 4))
               0: f = 3'd0; 1: f = 3'd1; 2: f = 3'd2;
               3: f = 3'd4; default: f = 3'd5;
             endcase
      sz = 1 << f[1:0];
      a  = $urandom;
      if ($urandom_range(0, 9) < 7) a = a - (a % sz);
      run_access(w, f, a, $urandom, $urandom, $urandom_range(0, 6),
                 $urandom_range(0, 5), ($urandom_range(0, 9) == 0),
                 $urandom_range(0, 2));
    end
  endtask

  initial begin
    rst = 1'b1; rd = 1'b0; wr = 1'b0; flush = 1'b0; op = 3'd0;
    alu = 32'd0; wd = 32'd0; exp_exc = 32'd0;
    dbus.ready = 1'b0; dbus.rvalid = 1'b0; dbus.rdata = 32'd0;
    test_reset();
    test_store_word();
    test_store_byte();
    test_load_byte();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
